// File: rtl/key_scan_ctrl.sv
// Matrix keypad scanner: walks 4 active-low columns, decodes 5 rows into key codes 1..25 and
// debounces over whole scan frames. Define KEY_SCAN_REPEAT_EN to add auto-repeat of key_valid.
module key_scan_ctrl #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEB_FRAMES = 4,
  parameter int unsigned CNT_W      = 10
`ifdef KEY_SCAN_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DLY = 125,
  parameter int unsigned REPEAT_PER = 25
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_in,
  output logic [3:0] key_col_out,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DW = (DEB_FRAMES < 2) ? 1 : $clog2(DEB_FRAMES + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(SCAN_DIV - 1);
  localparam logic [DW-1:0]    DebMax = DW'(DEB_FRAMES);
  localparam logic [4:0]       Ghost  = 5'd31;

  typedef enum logic [1:0] {StIdle, StPressDeb, StHeld, StReleaseDeb} state_e;

  typedef struct packed {
    logic       hit;
    logic       inv;
    logic [4:0] code;
  } col_res_t;

  function automatic col_res_t col_decode(input logic [1:0] c, input logic [4:0] rows);
    col_res_t   res;
    logic [4:0] base;
    base = 5'({c, 2'b00}) + 5'(c);
    res  = '{hit: 1'b0, inv: 1'b0, code: 5'd0};
    case (rows)
      5'b11111: ;
      5'b11110: res = '{hit: 1'b1, inv: 1'b0, code: base + 5'd1};
      5'b11101: res = '{hit: 1'b1, inv: 1'b0, code: base + 5'd2};
      5'b11011: res = '{hit: 1'b1, inv: 1'b0, code: base + 5'd3};
      5'b10111: res = '{hit: 1'b1, inv: 1'b0, code: base + 5'd4};
      5'b01111: res = '{hit: 1'b1, inv: 1'b0, code: base + 5'd5};
      5'b01110: res = '{hit: 1'b1, inv: 1'b0, code: 5'd21 + 5'(c)};
      default:  res = '{hit: 1'b0, inv: 1'b1, code: 5'd0};
    endcase
    return res;
  endfunction

  // Scan timing and per-column row capture
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       col_q;
  logic [4:0]       rows_q [4];
  logic             frame_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      col_q        <= 2'd0;
      key_col_out  <= 4'b1110;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) rows_q[i] <= 5'h1f;
    end else begin
      frame_done_q <= 1'b0;
      if (cnt_q == CntMax) begin
        cnt_q          <= '0;
        col_q          <= col_q + 2'd1;
        key_col_out    <= ~(4'b0001 << (col_q + 2'd1));
        rows_q[col_q]  <= key_in;
        frame_done_q   <= (col_q == 2'd3);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Frame candidate: 0 = nothing, 1..25 = key, 31 = ghost/invalid
  col_res_t   col_res [4];
  logic [2:0] n_hit;
  logic       any_inv;
  logic [4:0] hit_code;
  logic [4:0] cand;
  logic       cand_ok;

  always_comb begin
    n_hit    = 3'd0;
    any_inv  = 1'b0;
    hit_code = 5'd0;
    for (int i = 0; i < 4; i++) begin
      col_res[i] = col_decode(2'(i), rows_q[i]);
      if (col_res[i].inv) any_inv = 1'b1;
      if (col_res[i].hit) begin
        n_hit    = n_hit + 3'd1;
        hit_code = col_res[i].code;
      end
    end
    if (any_inv) begin
      cand = Ghost;
    end else if (n_hit == 3'd0) begin
      cand = 5'd0;
    end else if (n_hit == 3'd1) begin
      cand = hit_code;
    end else if (n_hit == 3'd2 && rows_q[0] == 5'b11110 && rows_q[1] == 5'b11110) begin
      cand = 5'd25;
    end else begin
      cand = Ghost;
    end
    cand_ok = (cand >= 5'd1) && (cand <= 5'd25);
  end

  // Debounce FSM with registered outputs
  state_e        state_q;
  logic [DW-1:0] deb_q;
  logic [DW-1:0] deb_inc;
  logic [4:0]    pend_q;

  assign deb_inc = deb_q + DW'(1);

`ifdef KEY_SCAN_REPEAT_EN
  logic [15:0] rep_cnt_q;
  logic        rep_phase_q;
  logic [15:0] rep_inc;
  logic [15:0] rep_lim;

  assign rep_inc = rep_cnt_q + 16'd1;
  assign rep_lim = rep_phase_q ? 16'(REPEAT_PER) : 16'(REPEAT_DLY);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      deb_q     <= '0;
      pend_q    <= 5'd0;
      key_code  <= 5'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
      rep_cnt_q   <= 16'd0;
      rep_phase_q <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (frame_done_q) begin
        unique case (state_q)
          StIdle: begin
            if (cand_ok) begin
              pend_q <= cand;
              if (DEB_FRAMES == 1) begin
                state_q   <= StHeld;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state_q <= StPressDeb;
                deb_q   <= DW'(1);
              end
            end
          end
          StPressDeb: begin
            if (cand == pend_q) begin
              if (deb_inc == DebMax) begin
                state_q   <= StHeld;
                key_code  <= pend_q;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                deb_q <= deb_inc;
              end
            end else if (cand_ok) begin
              pend_q <= cand;
              deb_q  <= DW'(1);
            end else begin
              state_q <= StIdle;
            end
          end
          StHeld: begin
            if (cand != key_code) begin
              if (DEB_FRAMES == 1) begin
                state_q  <= StIdle;
                key_held <= 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
                rep_cnt_q   <= 16'd0;
                rep_phase_q <= 1'b0;
`endif
              end else begin
                state_q <= StReleaseDeb;
                deb_q   <= DW'(1);
              end
            end else begin
`ifdef KEY_SCAN_REPEAT_EN
              if (rep_inc == rep_lim) begin
                key_valid   <= 1'b1;
                rep_cnt_q   <= 16'd0;
                rep_phase_q <= 1'b1;
              end else begin
                rep_cnt_q <= rep_inc;
              end
`endif
            end
          end
          StReleaseDeb: begin
            if (cand == key_code) begin
              state_q <= StHeld;
            end else if (deb_inc == DebMax) begin
              state_q  <= StIdle;
              key_held <= 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
              rep_cnt_q   <= 16'd0;
              rep_phase_q <= 1'b0;
`endif
            end else begin
              deb_q <= deb_inc;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: keypad switch-matrix model, directed frame table and random
// key sequences checked against a frame-level debounce model.
module tb_key_scan_ctrl;

  localparam int unsigned SCAN_DIV   = 8;
  localparam int unsigned DEB_FRAMES = 3;
  localparam int unsigned CNT_W      = 3;
  localparam int          FrameCyc   = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] key_in = 5'h1f;
  logic [3:0] key_col_out;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_held;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always #50 clk = ~clk;

  key_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_FRAMES(DEB_FRAMES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_col_out(key_col_out),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  // Keypad: sw[r][c] closed switches; rows respond one clock after the columns.
  logic [3:0] sw [5];
  bit         force_inv = 1'b0;

  function automatic logic [4:0] kp_rows(input int c);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = ~sw[i][c];
    if (force_inv && c == 2) r = 5'b10110;
    return r;
  endfunction

  always @(posedge clk) begin
    logic [4:0] r;
    r = 5'h1f;
    for (int c = 0; c < 4; c++) if (!key_col_out[c]) r = r & kp_rows(c);
    key_in <= r;
  end

  function automatic void press(input int k);
    int c;
    if (k >= 1 && k <= 20) begin
      c = (k - 1) / 5;
      sw[(k - 1) % 5][c] = 1'b1;
    end else if (k >= 21 && k <= 24) begin
      sw[0][k - 21] = 1'b1;
      sw[4][k - 21] = 1'b1;
    end else if (k == 25) begin
      sw[0][0] = 1'b1;
      sw[0][1] = 1'b1;
    end
  endfunction

  function automatic void set_keys(input int k1, input int k2, input bit inv);
    for (int i = 0; i < 5; i++) sw[i] = 4'b0000;
    force_inv = inv;
    press(k1);
    press(k2);
  endfunction

  // Spec-level frame candidate computed from what the keypad presents per column.
  function automatic int model_cand();
    int hits, code, z;
    bit bad;
    logic [4:0] p;
    hits = 0;
    code = 0;
    bad  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      p = kp_rows(c);
      z = 5 - $countones(p);
      if (z == 1) begin
        hits++;
        for (int r = 0; r < 5; r++) if (!p[r]) code = c * 5 + r + 1;
      end else if (p == 5'b01110) begin
        hits++;
        code = 21 + c;
      end else if (z != 0) begin
        bad = 1'b1;
      end
    end
    if (bad) return 31;
    if (hits == 0) return 0;
    if (hits == 1) return code;
    if (hits == 2 && kp_rows(0) == 5'b11110 && kp_rows(1) == 5'b11110) return 25;
    return 31;
  endfunction

  // Debounce model: run length of a matching candidate while free, miss length while held.
  int m_code, m_pend, m_run, m_miss;
  bit m_held;

  function automatic void model_reset();
    m_code = 0;
    m_pend = 0;
    m_run  = 0;
    m_miss = 0;
    m_held = 1'b0;
  endfunction

  task automatic model_step(input int cand, output bit ev, output int ec, output bit eh);
    bit ok;
    ok = (cand >= 1 && cand <= 25);
    ev = 1'b0;
    if (!m_held) begin
      if (ok && cand == m_pend) m_run++;
      else if (ok) begin
        m_pend = cand;
        m_run  = 1;
      end else begin
        m_pend = 0;
        m_run  = 0;
      end
      if (m_run == DEB_FRAMES) begin
        m_held = 1'b1;
        m_code = m_pend;
        ev     = 1'b1;
        m_pend = 0;
        m_run  = 0;
        m_miss = 0;
      end
    end else begin
      if (cand == m_code) m_miss = 0;
      else m_miss++;
      if (m_miss == DEB_FRAMES) begin
        m_held = 1'b0;
        m_miss = 0;
      end
    end
    ec = m_code;
    eh = m_held;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
    end
  endtask

  function automatic int col_exp(input int n);
    int c;
    c = (n / SCAN_DIV) % 4;
    return 15 & ~(1 << c);
  endfunction

  // Entered just after edge 32f+1; the frame's FSM result appears after edge 32f+33.
  task automatic run_frame(input int k1, input int k2, input bit inv, input bit ev,
                           input int ec, input bit eh);
    set_keys(k1, k2, inv);
    for (int i = 0; i < FrameCyc; i++) begin
      @(posedge clk);
      #1;
      edge_n++;
      check("key_col_out", key_col_out, col_exp(edge_n));
      check("key_valid", key_valid, (i == FrameCyc - 1) ? int'(ev) : 0);
    end
    check("key_code", key_code, ec);
    check("key_held", key_held, eh);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"}, key_col_out, 4'b1110);
    check({tag, "_code"}, key_code, 0);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_held"}, key_held, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    edge_n = 1;
    model_reset();
  endtask

  typedef struct {
    int key;
    bit inv;
    bit ev;
    int ec;
    bit eh;
  } vec_t;

  vec_t pre [$];
  vec_t post [$];

  function automatic void add(inout vec_t q [$], input int n, input int key, input bit inv,
                              input bit ev, input int ec, input bit eh);
    vec_t v;
    v = '{key: key, inv: inv, ev: ev, ec: ec, eh: eh};
    for (int i = 0; i < n; i++) q.push_back(v);
  endfunction

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ev, eh;
    int ec, k1, k2, len, kind;
    bit inv;

    set_keys(0, 0, 1'b0);

    // Directed frames, expected values derived by hand for DEB_FRAMES=3.
    add(pre, 10, 0, 0, 0, 0, 0);
    add(pre, 2, 13, 0, 0, 0, 0);   add(pre, 1, 13, 0, 1, 13, 1);  add(pre, 3, 13, 0, 0, 13, 1);
    add(pre, 2, 0, 0, 0, 13, 1);   add(pre, 1, 0, 0, 0, 13, 0);
    add(pre, 2, 7, 0, 0, 13, 0);   add(pre, 1, 0, 0, 0, 13, 0);
    add(pre, 2, 25, 0, 0, 13, 0);  add(pre, 1, 25, 0, 1, 25, 1);  add(pre, 1, 25, 0, 0, 25, 1);
    add(pre, 2, 0, 0, 0, 25, 1);   add(pre, 2, 0, 0, 0, 25, 0);
    add(pre, 2, 22, 0, 0, 25, 0);  add(pre, 1, 22, 0, 1, 22, 1);  add(pre, 1, 22, 0, 0, 22, 1);
    add(pre, 2, 0, 0, 0, 22, 1);   add(pre, 2, 0, 0, 0, 22, 0);
    add(pre, 2, 24, 0, 0, 22, 0);  add(pre, 1, 24, 0, 1, 24, 1);  add(pre, 1, 24, 0, 0, 24, 1);
    add(pre, 2, 0, 0, 0, 24, 1);   add(pre, 2, 0, 0, 0, 24, 0);
    add(pre, 5, 0, 1, 0, 24, 0);
    add(pre, 2, 3, 0, 0, 24, 0);
    // After mid-debounce reset: key 3 re-debounces from scratch, then 3 -> 8 without release.
    add(post, 2, 3, 0, 0, 0, 0);   add(post, 1, 3, 0, 1, 3, 1);
    add(post, 2, 8, 0, 0, 3, 1);   add(post, 3, 8, 0, 0, 3, 0);   add(post, 1, 8, 0, 1, 8, 1);
    add(post, 2, 0, 0, 0, 8, 1);   add(post, 1, 0, 0, 0, 8, 0);

    #20 rst = 1'b0;
    #10 check_reset_vals("reset");
    repeat (3) @(posedge clk);
    release_reset();

    foreach (pre[i]) run_frame(pre[i].key, 0, pre[i].inv, pre[i].ev, pre[i].ec, pre[i].eh);

    // Key 3 still mid-press-debounce: reset part-way through the next frame.
    repeat (9) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_vals("async_reset");
    @(posedge clk);
    #1 check_reset_vals("reset_hold");
    release_reset();

    foreach (post[i]) run_frame(post[i].key, 0, post[i].inv, post[i].ev, post[i].ec,
                                post[i].eh);

    // Random key sequences, including ghost combinations and invalid rows.
    set_keys(0, 0, 1'b0);
    rst = 1'b0;
    #1 check_reset_vals("reset_rand");
    release_reset();
    for (int s = 0; s < 30; s++) begin
      kind = $urandom_range(0, 9);
      k1   = 0;
      k2   = 0;
      inv  = 1'b0;
      if (kind == 3) begin
        k1 = $urandom_range(1, 25);
        k2 = $urandom_range(1, 25);
      end else if (kind == 4) begin
        inv = 1'b1;
      end else if (kind > 4) begin
        k1 = $urandom_range(1, 25);
      end
      len = $urandom_range(1, 5);
      for (int f = 0; f < len; f++) begin
        set_keys(k1, k2, inv);
        model_step(model_cand(), ev, ec, eh);
        run_frame(k1, k2, inv, ev, ec, eh);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_scan_ctrl.md
Name: key_scan_ctrl

Overview:
- Matrix keypad scanner that drives the 4 keypad column lines and reads back the 5 row lines.
- Decodes the row/column pair into a 5-bit key code (1..25), debounces over whole scan frames, and emits a one-cycle key event plus a held level to the application logic.
- Runs on the 10 MHz system clock.
- Its column output connects directly to the keypad model's column input; the model's row output connects to this block's row input.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is held low (dwell). Minimum 4.
- DEB_FRAMES, 4, consecutive identical scan frames required to accept a press or a release. Minimum 1.
- CNT_W, 10, width of the dwell counter. Must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  in  1  10 MHz system clock
- rst  in  1  reset, asynchronous, active-low
- key_in  in  5  row lines from the keypad, active-low
- key_col_out  out  4  column drive, exactly one bit low
- key_code  out  5  last accepted key code; 0 = none
- key_valid  out  1  one-cycle pulse when key_code is newly accepted
- key_held  out  1  high while the accepted key remains pressed

Behaviour:
- Reset (rst=0, asynchronous):
  - key_col_out=4'b1110; key_code=0; key_valid=0; key_held=0.
  - Dwell counter=0, column index=0, FSM=IDLE, frame accumulators cleared.
- Scan:
  - Dwell counter counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps and the column index advances 0→1→2→3→0.
  - key_col_out = ~(1<<col), registered.
  - key_in is sampled in the cycle where counter=SCAN_DIV-1. Earlier cycles are ignored, which absorbs the keypad's one-cycle registered response.
- Per-column decode, with c = column index:
  - single row r low (r=0..4) → c*5+r+1
  - 5'b01110 → 21+c
  - 5'b11111 → no key
  - any other pattern → invalid
- Frame = 4 consecutive column samples (col 0..3), ending at the col-3 sample. Frame candidate:
  - no column hit → 0
  - exactly one column hit → that code
  - only col0 and col1 both read 5'b11110 → 25
  - any invalid pattern or any other multi-column combination → 31 (ghost; never reported)
- frame_done: an internal one-cycle strobe in the cycle after the col-3 sample.
- FSM, updated on frame_done:
  - IDLE: candidate in 1..25 → PRESS_DEB, deb_cnt=1, pend=candidate.
  - PRESS_DEB:
    - candidate==pend → deb_cnt+1; when deb_cnt reaches DEB_FRAMES → HELD.
    - candidate!=pend → IDLE. A different valid candidate restarts PRESS_DEB with that code.
  - HELD:
    - candidate==key_code → stay.
    - otherwise → RELEASE_DEB, deb_cnt=1.
  - RELEASE_DEB:
    - candidate==key_code → HELD.
    - otherwise deb_cnt+1; when deb_cnt reaches DEB_FRAMES → IDLE.
  - DEB_FRAMES=1: transitions complete on the first qualifying frame.
- Entering HELD: key_code<=pend and key_valid=1, both registered in the cycle after frame_done. key_valid drops after one cycle. key_held=1 in HELD and RELEASE_DEB, 0 otherwise.
- Leaving to IDLE: key_held<=0. key_code keeps the last accepted value (no clear on release).
- Ghost candidate (31): counts as "not the same key" in every state. It is never accepted.
- Key change without an intervening release (HELD, new code): goes through RELEASE_DEB, then IDLE, then PRESS_DEB. A new key_valid fires only after full release and re-debounce.
- Reset mid-frame or mid-debounce: everything returns to the reset values immediately. No key_valid is emitted on reset exit.

Optional Feature:
- Macro KEY_SCAN_REPEAT_EN.
- Defined: adds parameters REPEAT_DLY (default 125 frames) and REPEAT_PER (default 25 frames).
  - In HELD, a frame counter starts at entry.
  - After REPEAT_DLY frames, key_valid pulses again, then every REPEAT_PER frames, with the same key_code.
  - The counter resets on leaving HELD.
  - The counter pauses in RELEASE_DEB; it resumes, without reset, on return to HELD.
- Undefined: exactly one key_valid per accepted press.

Test Plan:
All scenarios use SCAN_DIV=8 and DEB_FRAMES=3, with the keypad model wired to the column/row ports.
- Reset then idle 10 frames, no key → key_col_out cycles 1110/1101/1011/0111 every 8 clocks; key_valid never asserts; key_code=0.
- Key 13 held 6 frames → single key_valid pulse ending frame 3 (+1 clk); key_code=13; key_held=1. Release → key_held=0 after 3 empty frames; key_code stays 13.
- Key 7 pressed for 2 frames only → no key_valid; FSM back to IDLE.
- Key 25, then key 22, then key 24, each held 4 frames with 4-frame gaps → key_code sequence 25, 22, 24, one pulse each.
- Rows forced to 5'b10110 on col 2 (invalid) for 5 frames → no key_valid. Reset asserted mid-PRESS_DEB for key 3 → outputs return to reset values within the same cycle.
- With KEY_SCAN_REPEAT_EN, REPEAT_DLY=4, REPEAT_PER=2, key 18 held 12 frames → key_valid at accept, then at accept+4, +6, +8 frames; key_code=18 throughout.
